serializer_8to1: RTL and testbench

- Byte-to-bit serializer in the clk32f domain, downstream of the clock generator (clk32f / clk4f / clk2f / clk).
- Consumes one byte per 8 clk32f cycles (clk4f byte rate) and drives a single serial line, MSB first.
- After reset it emits a fixed run of comma bytes for receiver alignment, then carries data bytes.
- When no data byte is offered at a byte boundary, it fills that slot with an idle byte.

---
 rtl/serializer_8to1_if.sv | 29 ++
 rtl/serializer_8to1.sv | 98 +++++++++
 tb/tb_serializer_8to1.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serializer_8to1_if.sv
// Byte-in / bit-out bus of the 8:1 serializer.
// slave  : the serializer itself (takes bytes, drives the serial line).
// master : the upstream byte source and serial-line observer.
interface serializer_8to1_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic       data_out;
  logic       byte_start;
  logic       sync_done;

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_in,
    output data_out,
    output byte_start,
    output sync_done
  );

  modport master (
    output data_in,
    output valid_in,
    input  ready_in,
    input  data_out,
    input  byte_start,
    input  sync_done
  );
endinterface

// File: rtl/serializer_8to1.sv
// 8:1 byte-to-bit serializer in the clk32f domain, MSB first.
// After reset it sends COM_COUNT comma bytes for receiver alignment, then
// carries data bytes, filling empty byte slots with IDLE. One byte every
// 8 clk32f cycles, never any gap.
// Optional feature: define SERIALIZER_TXCOUNT_EN to add a saturating 16-bit
// count (tx_count) of accepted data bytes.
module serializer_8to1 #(
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter logic [7:0] IDLE      = 8'h7C,
  parameter int         COM_COUNT = 4        // 1..15
) (
  input  logic               clk32f,
  input  logic               rst,            // asynchronous, active-low
  serializer_8to1_if.slave   bus
`ifdef SERIALIZER_TXCOUNT_EN
  ,
  output logic [15:0]        tx_count
`endif
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t     state, state_next;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic [7:0] load_byte;
  logic       boundary;
  logic       last_comma;
  logic       accept;

  // bit_cnt==7 means the last bit of the current byte is on the line, so the
  // next edge loads a fresh byte.
  assign boundary   = (bit_cnt == 3'd7);
  assign last_comma = (com_cnt == 4'(COM_COUNT - 1));
  assign accept     = bus.ready_in && bus.valid_in;

  // State register: SYNC until the last comma is loaded, then ACTIVE until reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk32f or negedge rst) begin
    if (!rst) state <= SYNC;
    else      state <= state_next;
  end

  // Next state and byte selection for the coming boundary.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_byte  = IDLE;
    case (state)
      SYNC: begin
        load_byte = COMMA;
        if (boundary && last_comma) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (bus.valid_in) load_byte = bus.data_in;
      end
      default: state_next = SYNC;
    endcase
  end

  // Shift register and counters: load at a boundary, otherwise shift left.
  // NOTE: all state here is plain flops (no memory array), so all of it is
  // put into a known value by the asynchronous reset.
  always_ff @(posedge clk32f or negedge rst) begin
    if (!rst) begin
      sh      <= 8'h00;
      bit_cnt <= 3'd7;
      com_cnt <= 4'd0;
    end else if (boundary) begin
      sh      <= load_byte;
      bit_cnt <= 3'd0;
      if (state == SYNC) com_cnt <= com_cnt + 4'd1;
    end else begin
      sh      <= {sh[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign bus.data_out   = sh[7];
  assign bus.byte_start = (bit_cnt == 3'd0);
  assign bus.sync_done  = (state == ACTIVE);
  assign bus.ready_in   = (state == ACTIVE) && boundary;

`ifdef SERIALIZER_TXCOUNT_EN
  // Count accepted data bytes, holding at all-ones.
  always_ff @(posedge clk32f or negedge rst) begin
    if (!rst)                              tx_count <= 16'h0000;
    else if (accept && tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_serializer_8to1.sv
// Self-checking bench for serializer_8to1. A stream-level model predicts
// every serial bit from edge numbers counted since reset release.
module tb_serializer_8to1;

  localparam logic [7:0] COMMA     = 8'hBC;
  localparam logic [7:0] IDLE      = 8'h7C;
  localparam int         COM_COUNT = 4;

  logic clk32f = 1'b0;
  logic rst    = 1'b0;

  serializer_8to1_if bus ();

`ifdef SERIALIZER_TXCOUNT_EN
  logic [15:0] tx_count;
`endif

  serializer_8to1 #(.COMMA(COMMA), .IDLE(IDLE), .COM_COUNT(COM_COUNT)) dut (
    .clk32f (clk32f),
    .rst    (rst),
    .bus    (bus.slave)
`ifdef SERIALIZER_TXCOUNT_EN
    ,
    .tx_count (tx_count)
`endif
  );

  always #5 clk32f = ~clk32f;

  int         errors = 0;
  int         checks = 0;
  // Model: n = rising edges since reset release; cur = byte on the line.
  int         n = 0;
  logic [7:0] cur = 8'h00;
  int         acc_cnt = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at n=%0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_do, exp_bs, exp_sd, exp_rdy;
    int   pos;
    if (n == 0) begin
      exp_do = 1'b0; exp_bs = 1'b0; exp_sd = 1'b0; exp_rdy = 1'b0;
    end else begin
      pos     = (n - 1) % 8;
      exp_do  = cur[7 - pos];
      exp_bs  = (pos == 0);
      exp_sd  = (n >= 8 * COM_COUNT - 7);
      exp_rdy = exp_sd && (n % 8 == 0);
    end
    check("data_out",   16'(bus.data_out),   16'(exp_do));
    check("byte_start", 16'(bus.byte_start), 16'(exp_bs));
    check("sync_done",  16'(bus.sync_done),  16'(exp_sd));
    check("ready_in",   16'(bus.ready_in),   16'(exp_rdy));
  endtask

  // Drive inputs for one edge, advance the model, check at the falling edge.
  task automatic step(input logic v, input logic [7:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk32f);
    n++;
    if ((n - 1) % 8 == 0) begin
      if ((n - 1) / 8 < COM_COUNT) cur = COMMA;
      else if (v) begin cur = d; acc_cnt++; end
      else cur = IDLE;
    end
    @(negedge clk32f);
    check_outputs();
  endtask

  // Assert reset now (no clock edge needed), hold across edges, release.
  task automatic reset_cycle(input logic v, input logic [7:0] d);
    rst = 1'b0;
    #1;
    n = 0; cur = 8'h00; acc_cnt = 0;
    check_outputs();
    repeat (2) @(posedge clk32f);
    @(negedge clk32f);
    check_outputs();
`ifdef SERIALIZER_TXCOUNT_EN
    check("tx_count_reset", tx_count, 16'h0000);
`endif
    bus.valid_in = v;
    bus.data_in  = d;
    #1 rst = 1'b1;
    check_outputs();
  endtask

  task automatic align_boundary();
    while (n % 8 != 0) step(1'b0, 8'h00);
  endtask

  logic [7:0] b2b [3];

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    b2b[0] = 8'h01; b2b[1] = 8'h80; b2b[2] = 8'hFF;
    @(negedge clk32f);

    // Commas then idles with valid_in low.
    reset_cycle(1'b0, 8'h00);
    repeat (48) step(1'b0, 8'h00);

    // A5 held from release: first taken at edge 33, then withdrawn.
    @(negedge clk32f);
    reset_cycle(1'b1, 8'hA5);
    repeat (33) step(1'b1, 8'hA5);
    repeat (16) step(1'b0, 8'h00);

    // Back-to-back 01, 80, FF, valid held across whole slots.
    align_boundary();
    for (int i = 0; i < 24; i++) step(1'b1, b2b[i / 8]);
    repeat (8) step(1'b0, 8'h00);

    // valid pulse while bit_cnt==3 is ignored; next slot is IDLE.
    while ((n - 1) % 8 != 3) step(1'b0, 8'h00);
    step(1'b1, 8'h55);
    repeat (12) step(1'b0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 8'($urandom));

    // Reset in the middle of a data byte (bit 4 of 0xFF on the line).
    align_boundary();
    step(1'b1, 8'hFF);
    repeat (3) step(1'b0, 8'h00);
    check("mid_byte_bit4", 16'(bus.data_out), 16'h0001);
    #2;
    reset_cycle(1'b0, 8'h00);
    repeat (40) step(1'b0, 8'h00);

`ifdef SERIALIZER_TXCOUNT_EN
    // Five accepted bytes interleaved with idles.
    for (int i = 0; i < 5; i++) begin
      align_boundary();
      step(1'b1, 8'($urandom));
      repeat (8) step(1'b0, 8'h00);
    end
    check("tx_count_five", tx_count, 16'(acc_cnt));
    check("tx_count_eq5",  tx_count, 16'd5);
    // Saturation at all-ones.
    force dut.tx_count = 16'hFFFF;
    #1 release dut.tx_count;
    align_boundary();
    step(1'b1, 8'h3C);
    repeat (2) step(1'b0, 8'h00);
    check("tx_count_sat", tx_count, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
